// File: rtl/mmu_pkg.sv
// mmu_pkg: TLB op encodings, op-unit FSM states, TLB sizing and the probe match rule
package mmu_pkg;
    localparam int TLB_ENTRIES = 32;
    localparam int IDX_W = 5;
    typedef enum logic [1:0] {
        OP_TLBR  = 2'b00,
        OP_TLBWI = 2'b01,
        OP_TLBWR = 2'b10,
        OP_TLBP  = 2'b11
    } op_e;
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_PROBE, S_DONE} state_e;
    // mask bits cover VPN2 bits [24:13]; the global bit bypasses the ASID compare
    function automatic logic probe_match(input logic [18:0] vpn_a, input logic [7:0] asid_a,
                                         input logic [18:0] vpn_b, input logic [7:0] asid_b,
                                         input logic [11:0] mask, input logic glob);
        return (((vpn_a ^ vpn_b) & ~{7'b0, mask}) == '0) && (asid_a == asid_b || glob);
    endfunction
endpackage

// File: rtl/tlb_op_unit_if.sv
// tlb_op_unit_if: op handshake, CP0 side, Wired/Random and TLB array buses of tlb_op_unit
interface tlb_op_unit_if;
    logic op_valid;
    logic [1:0] op_code;
    logic op_ready;
    logic op_done;
    logic [31:0] cp0_entryhi, cp0_pagemask, cp0_entrylo0, cp0_entrylo1, cp0_index;
    logic wired_we;
    logic [mmu_pkg::IDX_W-1:0] wired_val;
    logic [mmu_pkg::IDX_W-1:0] random;
    logic tlb_we;
    logic [mmu_pkg::IDX_W-1:0] tlb_widx;
    logic [31:0] tlb_wentryhi, tlb_wpagemask, tlb_wentrylo0, tlb_wentrylo1;
    logic [mmu_pkg::IDX_W-1:0] tlb_ridx;
    logic [31:0] tlb_rentryhi, tlb_rpagemask, tlb_rentrylo0, tlb_rentrylo1;
    logic cp0_upd_we;
    logic [31:0] cp0_upd_entryhi, cp0_upd_pagemask, cp0_upd_entrylo0, cp0_upd_entrylo1;
    logic index_we;
    logic [31:0] index_val;
    modport slave (
        input op_valid, op_code, cp0_entryhi, cp0_pagemask, cp0_entrylo0, cp0_entrylo1, cp0_index,
              wired_we, wired_val, tlb_rentryhi, tlb_rpagemask, tlb_rentrylo0, tlb_rentrylo1,
        output op_ready, op_done, random, tlb_we, tlb_widx, tlb_wentryhi, tlb_wpagemask,
               tlb_wentrylo0, tlb_wentrylo1, tlb_ridx, cp0_upd_we, cp0_upd_entryhi,
               cp0_upd_pagemask, cp0_upd_entrylo0, cp0_upd_entrylo1, index_we, index_val
    );
    modport master (
        output op_valid, op_code, cp0_entryhi, cp0_pagemask, cp0_entrylo0, cp0_entrylo1, cp0_index,
               wired_we, wired_val, tlb_rentryhi, tlb_rpagemask, tlb_rentrylo0, tlb_rentrylo1,
        input op_ready, op_done, random, tlb_we, tlb_widx, tlb_wentryhi, tlb_wpagemask,
              tlb_wentrylo0, tlb_wentrylo1, tlb_ridx, cp0_upd_we, cp0_upd_entryhi,
              cp0_upd_pagemask, cp0_upd_entrylo0, cp0_upd_entrylo1, index_we, index_val
    );
endinterface

// File: rtl/tlb_random_ctr.sv
// tlb_random_ctr: CP0 Random register counting down from the top entry to Wired, and the Wired register
module tlb_random_ctr import mmu_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic wired_we,
    input  logic [IDX_W-1:0] wired_val,
    output logic [IDX_W-1:0] random
);
    localparam logic [IDX_W-1:0] TOP = IDX_W'(TLB_ENTRIES - 1);
    logic [IDX_W-1:0] random_q, random_d, wired_q, wired_d;
    always_comb begin
        wired_d = wired_we ? wired_val : wired_q;
        random_d = (wired_we || random_q == wired_q) ? TOP : random_q - IDX_W'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            random_q <= TOP;
            wired_q <= '0;
        end else begin
            random_q <= random_d;
            wired_q <= wired_d;
        end
    end
    assign random = random_q;
endmodule

// File: rtl/tlb_op_unit.sv
// tlb_op_unit: sequences TLBR/TLBWI/TLBWR/TLBP against the TLB array and CP0.
// Define TLBP_EARLY_EXIT_EN to end a probe on its first hit instead of scanning every entry.
module tlb_op_unit import mmu_pkg::*; #(
    parameter int TLB_ENTRIES = mmu_pkg::TLB_ENTRIES
) (
    input logic clk,
    input logic rst,
    tlb_op_unit_if.slave bus
);
    state_e state_q, state_d;
    op_e op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d, cnt_q, cnt_d, fidx_q, fidx_d, rand_idx;
    logic found_q, found_d;
    logic [31:0] ehi_q, ehi_d, pm_q, pm_d;
    logic accept, hit, last, early_out, glob_w, unused_idx;
    op_e code;
    tlb_random_ctr u_rand (
        .clk(clk), .rst(rst), .wired_we(bus.wired_we), .wired_val(bus.wired_val), .random(rand_idx)
    );
    assign code = op_e'(bus.op_code);
    assign accept = bus.op_valid && state_q == S_IDLE;
    assign last = cnt_q == IDX_W'(TLB_ENTRIES - 1);
    assign hit = state_q == S_PROBE && probe_match(ehi_q[31:13], ehi_q[7:0], bus.tlb_rentryhi[31:13],
        bus.tlb_rentryhi[7:0], bus.tlb_rpagemask[24:13], bus.tlb_rentrylo0[0] & bus.tlb_rentrylo1[0]);
`ifdef TLBP_EARLY_EXIT_EN
    assign early_out = hit;
`else
    assign early_out = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        fidx_d = fidx_q;
        found_d = found_q;
        ehi_d = ehi_q;
        pm_d = pm_q;
        if (accept) begin
            op_d = code;
            idx_d = code == OP_TLBWR ? rand_idx : bus.cp0_index[IDX_W-1:0];
            ehi_d = bus.cp0_entryhi;
            pm_d = bus.cp0_pagemask;
            cnt_d = '0;
            found_d = 1'b0;
            state_d = code == OP_TLBR ? S_READ : code == OP_TLBP ? S_PROBE : S_WRITE;
        end
        // only the first hit is kept, so a full scan reports the lowest match
        if (state_q == S_PROBE) begin
            cnt_d = cnt_q + IDX_W'(1);
            found_d = found_q || hit;
            fidx_d = (hit && !found_q) ? cnt_q : fidx_q;
            state_d = (last || early_out) ? S_DONE : S_PROBE;
        end
        if (state_q == S_READ || state_q == S_WRITE) state_d = S_DONE;
        if (state_q == S_DONE) state_d = S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q <= OP_TLBR;
            idx_q <= '0;
            cnt_q <= '0;
            fidx_q <= '0;
            found_q <= 1'b0;
            ehi_q <= '0;
            pm_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            fidx_q <= fidx_d;
            found_q <= found_d;
            ehi_q <= ehi_d;
            pm_q <= pm_d;
        end
    end
    assign unused_idx = ^bus.cp0_index[31:IDX_W];
    assign glob_w = bus.cp0_entrylo0[0] & bus.cp0_entrylo1[0];
    assign bus.random = rand_idx;
    assign bus.op_ready = state_q == S_IDLE;
    assign bus.op_done = state_q == S_DONE;
    assign bus.tlb_we = state_q == S_WRITE;
    assign bus.tlb_widx = idx_q;
    assign bus.tlb_wentryhi = ehi_q;
    assign bus.tlb_wpagemask = pm_q;
    assign bus.tlb_wentrylo0 = {bus.cp0_entrylo0[31:1], glob_w};
    assign bus.tlb_wentrylo1 = {bus.cp0_entrylo1[31:1], glob_w};
    assign bus.tlb_ridx = state_q == S_PROBE ? cnt_q : idx_q;
    assign bus.cp0_upd_we = state_q == S_READ;
    assign bus.cp0_upd_entryhi = bus.tlb_rentryhi;
    assign bus.cp0_upd_pagemask = bus.tlb_rpagemask;
    assign bus.cp0_upd_entrylo0 = bus.tlb_rentrylo0;
    assign bus.cp0_upd_entrylo1 = bus.tlb_rentrylo1;
    assign bus.index_we = state_q == S_DONE && op_q == OP_TLBP;
    assign bus.index_val = found_q ? {{(32 - IDX_W){1'b0}}, fidx_q} : 32'h8000_0000;
endmodule

// File: tb/tb_tlb_op_unit.sv
// tb_tlb_op_unit: randomized self-checking bench for tlb_op_unit against a behavioural TLB/Random model
module tb_tlb_op_unit;
`ifdef TLBP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] mem_hi [32];
    logic [31:0] mem_pm [32];
    logic [31:0] mem_lo0 [32];
    logic [31:0] mem_lo1 [32];
    logic [4:0] exp_rand, exp_wired;
    int lat, n_we, n_upd, n_iwe, upd_k;
    logic [4:0] cap_widx;
    logic [31:0] cap_whi, cap_wpm, cap_wlo0, cap_wlo1, cap_uhi, cap_upm, cap_ulo0, cap_ulo1, cap_ival;

    tlb_op_unit_if bus();
    tlb_op_unit #(.TLB_ENTRIES(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.tlb_rentryhi = mem_hi[bus.tlb_ridx];
    assign bus.tlb_rpagemask = mem_pm[bus.tlb_ridx];
    assign bus.tlb_rentrylo0 = mem_lo0[bus.tlb_ridx];
    assign bus.tlb_rentrylo1 = mem_lo1[bus.tlb_ridx];

    always @(posedge clk) begin
        if (rst) begin
            exp_rand <= 5'd31;
            exp_wired <= 5'd0;
        end else if (bus.wired_we) begin
            exp_wired <= bus.wired_val;
            exp_rand <= 5'd31;
        end else begin
            exp_rand <= (exp_rand == exp_wired) ? 5'd31 : exp_rand - 5'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_probe(input logic [31:0] hi);
        for (int i = 0; i < 32; i++) begin
            logic [31:0] care;
            care = 32'hFFFF_E000 & ~(mem_pm[i] & 32'h01FF_E000);
            if ((((hi ^ mem_hi[i]) & care) == 32'h0) &&
                (hi[7:0] == mem_hi[i][7:0] || (mem_lo0[i][0] && mem_lo1[i][0])))
                return i;
        end
        return 32'h8000_0000;
    endfunction

    function automatic int ref_lat(input logic [31:0] r);
        return (r[31] || !EARLY) ? 33 : int'(r[4:0]) + 2;
    endfunction

    task automatic fill_miss();
        for (int i = 0; i < 32; i++) begin
            mem_hi[i] = {19'h40000 + 19'(i), 5'h0, 8'h11};
            mem_pm[i] = 32'h0;
            mem_lo0[i] = {$urandom} & 32'hFFFF_FFFE;
            mem_lo1[i] = {$urandom} & 32'hFFFF_FFFE;
        end
    endtask

    // issue one op from an idle sample point; records strobes until op_done, then steps to idle
    task automatic do_op(input logic [1:0] code);
        bus.op_valid = 1'b1;
        bus.op_code = code;
        tick();
        bus.op_valid = 1'b0;
        lat = -1; n_we = 0; n_upd = 0; n_iwe = 0; upd_k = -1;
        for (int k = 1; k <= 40; k++) begin
            if (bus.tlb_we) begin
                n_we++;
                cap_widx = bus.tlb_widx; cap_whi = bus.tlb_wentryhi; cap_wpm = bus.tlb_wpagemask;
                cap_wlo0 = bus.tlb_wentrylo0; cap_wlo1 = bus.tlb_wentrylo1;
            end
            if (bus.cp0_upd_we) begin
                n_upd++; upd_k = k;
                cap_uhi = bus.cp0_upd_entryhi; cap_upm = bus.cp0_upd_pagemask;
                cap_ulo0 = bus.cp0_upd_entrylo0; cap_ulo1 = bus.cp0_upd_entrylo1;
            end
            if (bus.index_we) begin
                n_iwe++; cap_ival = bus.index_val;
            end
            if (bus.op_done) begin
                lat = k;
                break;
            end
            tick();
        end
        if (n_we > 0) begin
            mem_hi[cap_widx] = cap_whi; mem_pm[cap_widx] = cap_wpm;
            mem_lo0[cap_widx] = cap_wlo0; mem_lo1[cap_widx] = cap_wlo1;
        end
        tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total++; if (bus.op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.op_ready); end
        total++; if (bus.random !== 5'd31) begin bad++; $display("FAIL reset_random got=%0d exp=31", bus.random); end
        total++;
        if ({bus.tlb_we, bus.cp0_upd_we, bus.index_we, bus.op_done} !== 4'b0) begin
            bad++; $display("FAIL reset_strobes got=%b exp=0000", {bus.tlb_we, bus.cp0_upd_we, bus.index_we, bus.op_done});
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 1; i <= 40; i++) begin
            tick();
            total++;
            if (bus.random !== 5'((31 - i) & 31)) begin
                bad++; $display("FAIL random_count cyc=%0d got=%0d exp=%0d", i, bus.random, (31 - i) & 31);
            end
        end
    endtask

    task automatic test_wired();
        int n;
        n = 0;
        while (exp_rand != 5'd3 && n < 40) begin tick(); n++; end
        total++; if (bus.random !== 5'd3) begin bad++; $display("FAIL wired_reach3 got=%0d exp=3", bus.random); end
        bus.wired_we = 1'b1; bus.wired_val = 5'd8;
        tick();
        bus.wired_we = 1'b0;
        total++; if (bus.random !== 5'd31) begin bad++; $display("FAIL wired_force got=%0d exp=31", bus.random); end
        for (int i = 1; i <= 30; i++) begin
            tick();
            total++;
            if (bus.random !== (i <= 23 ? 5'(31 - i) : 5'(31 - (i - 24)))) begin
                bad++; $display("FAIL wired_count cyc=%0d got=%0d exp=%0d", i, bus.random, i <= 23 ? 31 - i : 55 - i);
            end
        end
        bus.wired_we = 1'b1; bus.wired_val = 5'd0;
        tick();
        bus.wired_we = 1'b0;
    endtask

    task automatic test_tlbwi();
        bus.cp0_index = 32'd5;
        bus.cp0_entryhi = $urandom; bus.cp0_pagemask = $urandom;
        bus.cp0_entrylo0 = {$urandom} | 32'h1;
        bus.cp0_entrylo1 = {$urandom} & 32'hFFFF_FFFE;
        do_op(2'b01);
        total++; if (n_we !== 1) begin bad++; $display("FAIL wi_we_count got=%0d exp=1", n_we); end
        total++; if (cap_widx !== 5'd5) begin bad++; $display("FAIL wi_widx got=%0d exp=5", cap_widx); end
        total++;
        if (cap_wlo0 !== (bus.cp0_entrylo0 & 32'hFFFF_FFFE) || cap_wlo1 !== bus.cp0_entrylo1) begin
            bad++; $display("FAIL wi_lo got=%h/%h exp=%h/%h", cap_wlo0, cap_wlo1, bus.cp0_entrylo0 & 32'hFFFF_FFFE, bus.cp0_entrylo1);
        end
        total++;
        if (cap_whi !== bus.cp0_entryhi || cap_wpm !== bus.cp0_pagemask) begin
            bad++; $display("FAIL wi_hi_pm got=%h/%h exp=%h/%h", cap_whi, cap_wpm, bus.cp0_entryhi, bus.cp0_pagemask);
        end
        total++; if (lat !== 2) begin bad++; $display("FAIL wi_latency got=%0d exp=2", lat); end
        total++; if (n_upd + n_iwe !== 0) begin bad++; $display("FAIL wi_stray got=%0d exp=0", n_upd + n_iwe); end
    endtask

    task automatic test_tlbr();
        mem_hi[7] = 32'h0040_20A5; mem_pm[7] = $urandom; mem_lo0[7] = $urandom; mem_lo1[7] = $urandom;
        bus.cp0_index = 32'd7;
        do_op(2'b00);
        total++; if (upd_k !== 1 || n_upd !== 1) begin bad++; $display("FAIL r_upd_cycle got=%0d/%0d exp=1/1", upd_k, n_upd); end
        total++; if (cap_uhi !== 32'h0040_20A5) begin bad++; $display("FAIL r_entryhi got=%h exp=004020a5", cap_uhi); end
        total++;
        if (cap_upm !== mem_pm[7] || cap_ulo0 !== mem_lo0[7] || cap_ulo1 !== mem_lo1[7]) begin
            bad++; $display("FAIL r_rest got=%h/%h/%h exp=%h/%h/%h", cap_upm, cap_ulo0, cap_ulo1, mem_pm[7], mem_lo0[7], mem_lo1[7]);
        end
        total++; if (lat !== 2 || n_we !== 0) begin bad++; $display("FAIL r_lat_we got=%0d/%0d exp=2/0", lat, n_we); end
    endtask

    task automatic test_tlbp();
        logic [31:0] tgt;
        fill_miss();
        tgt = {19'h01234, 5'h0, 8'hA5};
        mem_hi[9] = tgt;
        mem_hi[20] = {19'h01234, 5'h0, 8'h33}; mem_lo0[20] = 32'h1; mem_lo1[20] = 32'h1;
        bus.cp0_entryhi = tgt;
        do_op(2'b11);
        total++; if (cap_ival !== 32'd9 || n_iwe !== 1) begin bad++; $display("FAIL p_hit_idx got=%h/%0d exp=9/1", cap_ival, n_iwe); end
        total++; if (lat !== (EARLY ? 11 : 33)) begin bad++; $display("FAIL p_hit_lat got=%0d exp=%0d", lat, EARLY ? 11 : 33); end
        bus.cp0_entryhi = {19'h05555, 5'h0, 8'hA5};
        do_op(2'b11);
        total++; if (cap_ival !== 32'h8000_0000) begin bad++; $display("FAIL p_miss_val got=%h exp=80000000", cap_ival); end
        total++; if (lat !== 33) begin bad++; $display("FAIL p_miss_lat got=%0d exp=33", lat); end
    endtask

    task automatic test_tlbp_random();
        logic [18:0] vpns [4];
        logic [31:0] r;
        vpns = '{19'h00100, 19'h00101, 19'h00300, 19'h7F100};
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 32; i++) begin
                mem_hi[i] = {vpns[$urandom_range(3)], 5'($urandom), ($urandom_range(1) == 1) ? 8'h5A : 8'hC3};
                mem_pm[i] = ($urandom_range(3) == 0) ? 32'h01FF_E000 : ($urandom_range(1) == 1) ? 32'h0000_6000 : 32'h0;
                mem_lo0[i] = $urandom; mem_lo1[i] = {$urandom} & (($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
            end
            bus.cp0_entryhi = {vpns[$urandom_range(3)] ^ 19'($urandom_range(3) << 1), 5'($urandom), ($urandom_range(1) == 1) ? 8'h5A : 8'hC3};
            r = ref_probe(bus.cp0_entryhi);
            do_op(2'b11);
            total++; if (cap_ival !== r) begin bad++; $display("FAIL prand_val t=%0d got=%h exp=%h", t, cap_ival, r); end
            total++; if (lat !== ref_lat(r)) begin bad++; $display("FAIL prand_lat t=%0d got=%0d exp=%0d", t, lat, ref_lat(r)); end
        end
    endtask

    task automatic test_reset_mid();
        int k, strays;
        fill_miss();
        bus.cp0_entryhi = {19'h05555, 5'h0, 8'hA5};
        bus.op_valid = 1'b1; bus.op_code = 2'b11;
        tick();
        bus.op_valid = 1'b0;
        k = 1;
        while (bus.tlb_ridx !== 5'd12 && k < 40) begin tick(); k++; end
        total++; if (k !== 13) begin bad++; $display("FAIL rm_scan12 got=%0d exp=13", k); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.op_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", bus.op_ready); end
        strays = 0;
        for (int i = 0; i < 40; i++) begin
            strays += int'(bus.op_done) + int'(bus.index_we) + int'(bus.tlb_we);
            tick();
        end
        total++; if (strays !== 0) begin bad++; $display("FAIL rm_strobes got=%0d exp=0", strays); end
        total++; if (bus.random !== exp_rand) begin bad++; $display("FAIL rm_random got=%0d exp=%0d", bus.random, exp_rand); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] want;
        for (int t = 0; t < 4; t++) begin
            repeat ($urandom_range(5)) tick();
            want = exp_rand;
            bus.cp0_entryhi = $urandom; bus.cp0_pagemask = $urandom;
            bus.cp0_entrylo0 = $urandom; bus.cp0_entrylo1 = $urandom;
            do_op(2'b10);
            total++; if (cap_widx !== want || n_we !== 1) begin bad++; $display("FAIL wr_idx t=%0d got=%0d exp=%0d", t, cap_widx, want); end
            total++; if (bus.op_ready !== 1'b1 || bus.op_done !== 1'b0) begin bad++; $display("FAIL b2b_idle t=%0d got=%b%b exp=10", t, bus.op_ready, bus.op_done); end
            bus.cp0_index = {27'h5A5A5A5, want};
            do_op(2'b00);
            total++;
            if (cap_uhi !== bus.cp0_entryhi || cap_ulo0[0] !== (bus.cp0_entrylo0[0] & bus.cp0_entrylo1[0]) ||
                cap_ulo1[31:1] !== bus.cp0_entrylo1[31:1]) begin
                bad++; $display("FAIL b2b_readback t=%0d got=%h/%h exp=%h/%h", t, cap_uhi, cap_ulo0, bus.cp0_entryhi, bus.cp0_entrylo0);
            end
        end
    endtask

    initial begin
        bus.op_valid = 1'b0; bus.op_code = 2'b00;
        bus.cp0_entryhi = '0; bus.cp0_pagemask = '0; bus.cp0_entrylo0 = '0; bus.cp0_entrylo1 = '0; bus.cp0_index = '0;
        bus.wired_we = 1'b0; bus.wired_val = '0;
        for (int i = 0; i < 32; i++) begin
            mem_hi[i] = '0; mem_pm[i] = '0; mem_lo0[i] = '0; mem_lo1[i] = '0;
        end
        test_reset();
        test_random();
        test_wired();
        test_tlbwi();
        test_tlbr();
        test_tlbp();
        test_tlbp_random();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tlb_op_unit.md
TLB_OP_UNIT -- requirements
Module: tlb_op_unit

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 32, number of TLB entries; the index width is 5 bits.
REQ-002 SHALL have reset rst, synchronous, active-high, and clock clk; the ports are listed below.
- clk  in  1  clock
- rst  in  1  sync active-high reset
- op_valid  in  1  TLB instruction request
- op_code  in  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
- op_ready  out  1  unit idle, can accept
- op_done  out  1  one-cycle completion pulse
- cp0_entryhi, cp0_pagemask, cp0_entrylo0, cp0_entrylo1, cp0_index  in  32 each  CP0 register values
- wired_we  in  1  Wired register write
- wired_val  in  5  new Wired value
- random  out  5  current Random value
- tlb_we  out  1  TLB write strobe
- tlb_widx  out  5  write index
- tlb_wentryhi, tlb_wpagemask, tlb_wentrylo0, tlb_wentrylo1  out  32 each  write data
- tlb_ridx  out  5  read index
- tlb_rentryhi, tlb_rpagemask, tlb_rentrylo0, tlb_rentrylo1  in  32 each  combinational read data for tlb_ridx
- cp0_upd_we  out  1  load EntryHi/PageMask/EntryLo0/EntryLo1 from the upd buses
- cp0_upd_entryhi, cp0_upd_pagemask, cp0_upd_entrylo0, cp0_upd_entrylo1  out  32 each  TLBR result
- index_we  out  1  load Index from index_val
- index_val  out  32  TLBP result

Function
REQ-003 SHALL implement FSM IDLE, READ, WRITE, PROBE, DONE; op_ready=1 only in IDLE; accept on op_valid&op_ready.
REQ-004 SHALL go from IDLE on accept to READ (00), WRITE (01/10) or PROBE (11), latching cp0_entryhi, cp0_pagemask and the target index.
REQ-005 SHALL latch target index cp0_index[4:0] for TLBWI and random for TLBWR in the accept cycle.
REQ-006 SHALL assert tlb_we for exactly the single WRITE cycle: tlb_widx is the latched index, write data is the cp0 values, bit0 of both EntryLo outputs = cp0_entrylo0[0]&cp0_entrylo1[0]; WRITE->DONE.
REQ-007 SHALL in READ drive tlb_ridx=latched cp0_index[4:0] and assert cp0_upd_we with upd buses = tlb_r* that cycle; READ->DONE.
REQ-008 SHALL in PROBE scan tlb_ridx 0,1,...,31, one entry per cycle, starting at 0 on entry.
REQ-009 SHALL match an entry when VPN2 bits [31:13] agree outside mask M, where M = {7'b0, tlb_rpagemask[24:13]} masks VPN2 bits, and (ASID[7:0] equal, or tlb_rentrylo0[0]&tlb_rentrylo1[0]).
REQ-010 SHALL on probe completion pulse index_we with index_val={27'b0,idx} for the lowest matching idx, or 32'h8000_0000 on no match; index_we occurs in the DONE cycle.
REQ-011 SHALL pulse op_done for one cycle in DONE, then return to IDLE; latency from accept: TLBR 2, TLBWI/TLBWR 2, TLBP per REQ-017.
REQ-012 SHALL decrement random every cycle; if random==wired it loads 31 next cycle instead; wired==31 holds random at 31.
REQ-013 SHALL on wired_we load the wired register and force random to 31 next cycle, overriding the decrement; a TLBWR in flight keeps its latched index.
REQ-014 SHALL hold tlb_we, cp0_upd_we, index_we and op_done low outside their specified states.

Reset
REQ-015 SHALL on rst set state IDLE, random=31, wired=0, probe counter=0, all strobes 0; a reset mid-operation aborts with no write, no update and no op_done.

Configuration
REQ-016 SHALL, with TLBP_EARLY_EXIT_EN defined, leave PROBE on the first match: DONE follows the match cycle, so latency is idx+2 on a hit and 33 on a miss.
REQ-017 SHALL, without TLBP_EARLY_EXIT_EN, always scan all 32 entries (latency 33), keep the lowest matching idx, and produce results identical to the early-exit build.

Structure
REQ-018 SHALL place the op_code encodings, the FSM state enum, TLB_ENTRIES and the index width in the shared package mmu_pkg.
REQ-019 SHALL implement the Random/Wired logic as the sub-module tlb_random_ctr.

Verification
REQ-020 Reset, then count 40 cycles with wired=0 -> random reads 31,30,...,0,31,30,...
REQ-021 wired_we with wired_val=8 when random=3 -> random=31 next cycle, then counts down to 8 and wraps to 31.
REQ-022 TLBWI with cp0_index=5, lo0[0]=1, lo1[0]=0 -> one tlb_we, tlb_widx=5, both EntryLo bit0=0, op_done 2 cycles after accept.
REQ-023 TLBR of entry 7 holding EntryHi=32'h0040_20A5 -> cp0_upd_we with cp0_upd_entryhi=32'h0040_20A5 one cycle after accept.
REQ-024 TLBP where entries 9 and 20 match cp0_entryhi -> index_val=32'd9; latency 11 with TLBP_EARLY_EXIT_EN, 33 without; on a miss -> 32'h8000_0000.
REQ-025 Assert rst during PROBE at scan idx 12 -> no index_we or op_done, op_ready=1 the cycle after reset.
